// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes, coin values, payout states.
// Used by both the coin acceptor and the change dispenser.
package vend_pkg;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NONE = 2'b00;
  localparam coin_code_t COIN_5    = 2'b01;
  localparam coin_code_t COIN_10   = 2'b10;
  localparam coin_code_t COIN_25   = 2'b11;

  localparam int unsigned VAL_5  = 5;
  localparam int unsigned VAL_10 = 10;
  localparam int unsigned VAL_25 = 25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } disp_state_t;

  function automatic int unsigned coin_value(input coin_code_t code);
    case (code)
      COIN_5:  return VAL_5;
      COIN_10: return VAL_10;
      COIN_25: return VAL_25;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_picker.sv
// Combinational greedy selector: largest available coin whose value fits in remaining.
module coin_picker
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic             avail_25,
  input  logic             avail_10,
  input  logic             avail_5,
  output coin_code_t       code_c,
  output logic             none_fit_c
);

  logic [31:0] rem32;
  assign rem32 = 32'(remaining);

  always_comb begin
    code_c     = COIN_NONE;
    none_fit_c = 1'b0;
    if (avail_25 && (rem32 >= VAL_25))
      code_c = COIN_25;
    else if (avail_10 && (rem32 >= VAL_10))
      code_c = COIN_10;
    else if (avail_5 && (rem32 >= VAL_5))
      code_c = COIN_5;
    else
      none_fit_c = 1'b1;
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as a greedy sequence of 25/10/5 coins over a valid/ack coin bus.
// Optional COIN_INVENTORY_EN adds per-denomination stock counters and shortfall error.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W   = 8
`ifdef COIN_INVENTORY_EN
  ,
  parameter int unsigned STOCK_W = 6,
  parameter int unsigned INIT_25 = 8,
  parameter int unsigned INIT_10 = 8,
  parameter int unsigned INIT_5  = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output coin_code_t       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
`ifdef COIN_INVENTORY_EN
  ,
  output logic [STOCK_W-1:0] stock_25,
  output logic [STOCK_W-1:0] stock_10,
  output logic [STOCK_W-1:0] stock_5
`endif
);

  disp_state_t      state, state_n;
  logic [AMT_W-1:0] rem_n;
  coin_code_t       coin_n;
  logic             cv_n, done_n, err_n;
  logic             av25, av10, av5;
  coin_code_t       pick_c;
  logic             none_fit_c;

`ifdef COIN_INVENTORY_EN
  logic [STOCK_W-1:0] s25_n, s10_n, s5_n;
  assign av25 = (stock_25 != '0);
  assign av10 = (stock_10 != '0);
  assign av5  = (stock_5  != '0);
`else
  assign av25 = 1'b1;
  assign av10 = 1'b1;
  assign av5  = 1'b1;
`endif

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  coin_picker #(.AMT_W(AMT_W)) u_picker (
    .remaining  (remaining),
    .avail_25   (av25),
    .avail_10   (av10),
    .avail_5    (av5),
    .code_c     (pick_c),
    .none_fit_c (none_fit_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    coin_n  = coin_out;
    cv_n    = coin_valid;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef COIN_INVENTORY_EN
    s25_n   = stock_25;
    s10_n   = stock_10;
    s5_n    = stock_5;
`endif
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if ((32'(req_amount) % VAL_5) != 32'd0) begin
            err_n = 1'b1;
          end else if (req_amount == '0) begin
            rem_n   = '0;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            rem_n   = req_amount;
            state_n = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        // Only reachable with stock limits: unpaid shortfall stays in remaining
        if (none_fit_c) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          coin_n  = pick_c;
          cv_n    = 1'b1;
          state_n = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (coin_ack) begin
          rem_n  = remaining - AMT_W'(coin_value(coin_out));
          coin_n = COIN_NONE;
          cv_n   = 1'b0;
`ifdef COIN_INVENTORY_EN
          case (coin_out)
            COIN_25: if (stock_25 != '0) s25_n = stock_25 - STOCK_W'(1);
            COIN_10: if (stock_10 != '0) s10_n = stock_10 - STOCK_W'(1);
            COIN_5:  if (stock_5  != '0) s5_n  = stock_5  - STOCK_W'(1);
            default: ;
          endcase
`endif
          if (rem_n == '0) begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_SELECT;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      coin_out   <= COIN_NONE;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef COIN_INVENTORY_EN
      stock_25   <= STOCK_W'(INIT_25);
      stock_10   <= STOCK_W'(INIT_10);
      stock_5    <= STOCK_W'(INIT_5);
`endif
    end else begin
      state      <= state_n;
      remaining  <= rem_n;
      coin_out   <= coin_n;
      coin_valid <= cv_n;
      done       <= done_n;
      err        <= err_n;
`ifdef COIN_INVENTORY_EN
      stock_25   <= s25_n;
      stock_10   <= s10_n;
      stock_5    <= s5_n;
`endif
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; inventory scenarios run when COIN_INVENTORY_EN is defined.
module tb_change_dispenser;

  localparam int unsigned AMT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             busy;
  logic             done;
  logic             err;
  logic [AMT_W-1:0] remaining;
`ifdef COIN_INVENTORY_EN
  logic [5:0]       stock_25, stock_10, stock_5;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef COIN_INVENTORY_EN
  change_dispenser #(.AMT_W(AMT_W), .STOCK_W(6), .INIT_25(0), .INIT_10(4), .INIT_5(0)) dut (
`else
  change_dispenser #(.AMT_W(AMT_W)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .remaining  (remaining)
`ifdef COIN_INVENTORY_EN
    ,
    .stock_25   (stock_25),
    .stock_10   (stock_10),
    .stock_5    (stock_5)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called in a SELECT cycle; presents one coin, waits, acks, checks the payout.
  task automatic pay_coin(input string tag, input logic [1:0] code, input int rem_after, input int ack_delay);
    step();
    chk({tag, "_valid"}, 32'(coin_valid), 32'd1);
    chk({tag, "_code"}, 32'(coin_out), 32'(code));
    for (int i = 0; i < ack_delay; i++) begin
      step();
      chk({tag, "_hold_valid"}, 32'(coin_valid), 32'd1);
      chk({tag, "_hold_code"}, 32'(coin_out), 32'(code));
    end
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    chk({tag, "_drop"}, 32'(coin_valid), 32'd0);
    chk({tag, "_none"}, 32'(coin_out), 32'd0);
    chk({tag, "_rem"}, 32'(remaining), 32'(rem_after));
  endtask

  task automatic request(input logic [AMT_W-1:0] amt);
    req_valid  = 1'b1;
    req_amount = amt;
    step();
    req_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(coin_valid), 32'd0);
    chk("rst_coin", 32'(coin_out), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

`ifdef COIN_INVENTORY_EN
    chk("rst_s25", 32'(stock_25), 32'd0);
    chk("rst_s10", 32'(stock_10), 32'd4);
    chk("rst_s5", 32'(stock_5), 32'd0);

    // 30 with no quarters: three dimes
    request(8'd30);
    chk("inv30_rem", 32'(remaining), 32'd30);
    pay_coin("inv30_c1", 2'b10, 20, 0);
    pay_coin("inv30_c2", 2'b10, 10, 0);
    pay_coin("inv30_c3", 2'b10, 0, 0);
    chk("inv30_done", 32'(done), 32'd1);
    chk("inv30_s10", 32'(stock_10), 32'd1);
    step();

    // 15 with one dime and no nickels: shortfall of 5
    request(8'd15);
    pay_coin("inv15_c1", 2'b10, 5, 0);
    chk("inv15_s10", 32'(stock_10), 32'd0);
    step();
    chk("inv15_err", 32'(err), 32'd1);
    chk("inv15_rem", 32'(remaining), 32'd5);
    chk("inv15_valid", 32'(coin_valid), 32'd0);
    chk("inv15_nodone", 32'(done), 32'd0);
    chk("inv15_ready", 32'(req_ready), 32'd1);
    step();
    chk("inv15_err_end", 32'(err), 32'd0);
    chk("inv15_rem_hold", 32'(remaining), 32'd5);
    chk("inv15_s10_sat", 32'(stock_10), 32'd0);
`else
    // Ack while idle is ignored
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    chk("idle_ack_valid", 32'(coin_valid), 32'd0);
    chk("idle_ack_ready", 32'(req_ready), 32'd1);

    // 30, immediate ack: 25 then 5
    request(8'd30);
    chk("a30_n1_valid", 32'(coin_valid), 32'd0);
    chk("a30_n1_rem", 32'(remaining), 32'd30);
    chk("a30_n1_busy", 32'(busy), 32'd1);
    chk("a30_n1_ready", 32'(req_ready), 32'd0);
    pay_coin("a30_c1", 2'b11, 5, 0);
    chk("a30_mid_done", 32'(done), 32'd0);
    pay_coin("a30_c2", 2'b01, 0, 0);
    chk("a30_done", 32'(done), 32'd1);
    step();
    chk("a30_done_end", 32'(done), 32'd0);
    chk("a30_idle", 32'(req_ready), 32'd1);
    chk("a30_busy_end", 32'(busy), 32'd0);

    // 40, ack held off 3 cycles per coin: 25, 10, 5
    request(8'd40);
    pay_coin("a40_c1", 2'b11, 15, 3);
    pay_coin("a40_c2", 2'b10, 5, 3);
    chk("a40_mid_done", 32'(done), 32'd0);
    pay_coin("a40_c3", 2'b01, 0, 3);
    chk("a40_done", 32'(done), 32'd1);
    step();

    // Zero amount: done the cycle after accept, no coin
    request(8'd0);
    chk("a0_done", 32'(done), 32'd1);
    chk("a0_valid", 32'(coin_valid), 32'd0);
    chk("a0_busy", 32'(busy), 32'd1);
    step();
    chk("a0_done_end", 32'(done), 32'd0);
    chk("a0_ready", 32'(req_ready), 32'd1);

    // 17 is unpayable: err pulse, stay idle
    request(8'd17);
    chk("a17_err", 32'(err), 32'd1);
    chk("a17_ready", 32'(req_ready), 32'd1);
    chk("a17_valid", 32'(coin_valid), 32'd0);
    chk("a17_rem", 32'(remaining), 32'd0);
    chk("a17_done", 32'(done), 32'd0);
    step();
    chk("a17_err_end", 32'(err), 32'd0);
    chk("a17_valid2", 32'(coin_valid), 32'd0);

    // Request of 15 during a payout of 30 is ignored
    req_valid = 1'b1; req_amount = 8'd30;
    step();
    req_amount = 8'd15;
    step();
    req_valid = 1'b0;
    chk("ign_valid", 32'(coin_valid), 32'd1);
    chk("ign_code", 32'(coin_out), 32'd3);
    chk("ign_rem", 32'(remaining), 32'd30);
    coin_ack = 1'b1;
    step();
    coin_ack = 1'b0;
    chk("ign_rem2", 32'(remaining), 32'd5);
    pay_coin("ign_c2", 2'b01, 0, 0);
    chk("ign_done", 32'(done), 32'd1);
    step();
    step();
    chk("ign_no_rerun", 32'(busy), 32'd0);

    // Max amount 255: ten quarters then a nickel
    request(8'd255);
    for (int i = 0; i < 10; i++)
      pay_coin("a255_q", 2'b11, 230 - 25 * i, 0);
    pay_coin("a255_n", 2'b01, 0, 0);
    chk("a255_done", 32'(done), 32'd1);
    step();

    // 254 is not a multiple of 5
    request(8'd254);
    chk("a254_err", 32'(err), 32'd1);
    step();

    // Reset while presenting a quarter
    request(8'd30);
    step();
    chk("rmid_valid_pre", 32'(coin_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_valid", 32'(coin_valid), 32'd0);
    chk("rmid_rem", 32'(remaining), 32'd0);
    chk("rmid_ready", 32'(req_ready), 32'd1);
    chk("rmid_done", 32'(done), 32'd0);
    chk("rmid_err", 32'(err), 32'd0);
    step();
    chk("rmid_done2", 32'(done), 32'd0);
    chk("rmid_valid2", 32'(coin_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
